// File: rtl/ram_word_access_sequencer_if.sv
// MCU word-request bus plus the 16-bit RAM port, bundled for the word access sequencer.
// slave = sequencer view, master = MCU/RAM-side view.
interface ram_word_access_sequencer_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-2:0] req_addr;
  logic [3:0]            req_be;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [15:0]           ram_din;
  logic [1:0]            ram_write_en;
  logic [15:0]           ram_dout;

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, ram_dout,
    output req_ready, rsp_valid, rsp_rdata, ram_addr, ram_din, ram_write_en
  );

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, ram_dout,
    input  req_ready, rsp_valid, rsp_rdata, ram_addr, ram_din, ram_write_en
  );
endinterface

// File: rtl/ram_word_access_sequencer.sv
// Splits 32-bit word requests into low/high 16-bit RAM accesses and reassembles reads.
// Optional macro RAM_WORD_SEQ_SKIP_EN skips write phases whose byte-enable half is zero.
module ram_word_access_sequencer #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic clk,
  input  logic reset_n,
  ram_word_access_sequencer_if.slave bus
);
  localparam int WAW = ADDR_WIDTH - 1;

  typedef enum logic [1:0] {IDLE, LO, HI, RWAIT} state_e;

  state_e                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [15:0]           ram_din_q, ram_din_d;
  logic [1:0]            ram_we_q, ram_we_d;
  logic [WAW-1:0]        addr_q, addr_d;
  logic                  we_q, we_d;
  logic [15:0]           whi_q, whi_d;
  logic [1:0]            behi_q, behi_d;
  logic [15:0]           rlo_q, rlo_d;

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    ram_we_d    = 2'b00;
    addr_d      = addr_q;
    we_d        = we_q;
    whi_d       = whi_q;
    behi_d      = behi_q;
    rlo_d       = rlo_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          req_ready_d = 1'b0;
          addr_d      = bus.req_addr;
          we_d        = bus.req_we;
          whi_d       = bus.req_wdata[31:16];
          behi_d      = bus.req_be[3:2];
          ram_addr_d  = {bus.req_addr, 1'b0};
          state_d     = LO;
          if (bus.req_we) begin
            ram_din_d = bus.req_wdata[15:0];
            ram_we_d  = bus.req_be[1:0];
`ifdef RAM_WORD_SEQ_SKIP_EN
            // Empty low half: present the high phase now so the ack lands at E1.
            if (bus.req_be[1:0] == 2'b00) begin
              ram_addr_d = {bus.req_addr, 1'b1};
              ram_din_d  = bus.req_wdata[31:16];
              ram_we_d   = bus.req_be[3:2];
              state_d    = HI;
            end
`endif
          end
        end
      end
      LO: begin
        ram_addr_d = {addr_q, 1'b1};
        state_d    = HI;
        if (we_q) begin
          ram_din_d = whi_q;
          ram_we_d  = behi_q;
`ifdef RAM_WORD_SEQ_SKIP_EN
          if (behi_q == 2'b00) begin
            ram_we_d    = 2'b00;
            rsp_valid_d = 1'b1;
            req_ready_d = 1'b1;
            state_d     = IDLE;
          end
`endif
        end
      end
      HI: begin
        if (we_q) begin
          rsp_valid_d = 1'b1;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          rlo_d   = bus.ram_dout;
          state_d = RWAIT;
        end
      end
      RWAIT: begin
        rsp_rdata_d = {bus.ram_dout, rlo_q};
        rsp_valid_d = 1'b1;
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_we_q    <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      whi_q       <= '0;
      behi_q      <= '0;
      rlo_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      ram_we_q    <= ram_we_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      whi_q       <= whi_d;
      behi_q      <= behi_d;
      rlo_q       <= rlo_d;
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.ram_din      = ram_din_q;
  assign bus.ram_write_en = ram_we_q;
endmodule
